reg_flags_stk: RTL and testbench
================================

// Module: reg_flags_stk
//
// PURPOSE
// Parametrised successor to the single-bit flag registers. One register holds
// NFLAGS processor flags (V, L, Z, N, ...), loadable from IBUS or from ALU results
// under a per-flag mask. A DEPTH-entry LIFO shadow stack saves and restores the
// whole flag word on interrupt entry and return. Sits beside the ALU; drives the
// flag outputs to the control unit and the bus readback path.
//
// PARAMETERS
// NFLAGS     4    number of flag bits held (1..16)
// DEPTH      8    shadow stack entries (>=1)
// RESET_VAL  0    flag word value loaded on reset (NFLAGS bits)
// PTR_W      localparam = $clog2(DEPTH+1); width of the depth counter
//
// PORTS
// clk4       in   1        system clock; all state changes on rising edge
// nreset     in   1        asynchronous reset, active low
// ibus_f     in   NFLAGS   flag bits from IBUS (bus write/restore path)
// nflagwe    in   1        active low: load flags from ibus_f
// alu_f      in   NFLAGS   flag results from ALU
// alu_mask   in   NFLAGS   1 = this flag is updated by an ALU operation
// nread_alu  in   1        active low: masked load from alu_f
// npush      in   1        active low: push current flag word to the stack
// npop       in   1        active low: pop top of stack into the flags
// nerrclr    in   1        active low: clear sticky error bits
// flags      out  NFLAGS   current flag word (registered)
// depth      out  PTR_W    number of occupied stack entries
// empty      out  1        depth == 0
// full       out  1        depth == DEPTH
// ovf        out  1        sticky: push attempted while full
// unf        out  1        sticky: pop attempted while empty, or push+pop together
//
// BEHAVIOUR
// - Reset (nreset low, async): flags=RESET_VAL, depth=0, empty=1, full=0,
//   ovf=0, unf=0. Stack RAM contents are not reset (don't-care).
// - All controls sampled at the rising edge of clk4; every output is registered
//   and valid one edge after the request (latency 1). empty/full derive from depth.
// - Flag next value, highest priority first:
//   1. npop low, stack not empty, npush high: flags <= stack[top]
//   2. nflagwe low: flags <= ibus_f
//   3. nread_alu low: flags <= (flags & ~alu_mask) | (alu_f & alu_mask)
//   4. otherwise hold
//   A losing request is dropped silently (no error).
// - Push (npush low, npop high): not full -> stack[depth] <= flags (pre-edge value),
//   depth+1. A simultaneous bus/ALU load still updates flags in the same edge.
//   Full -> stack and depth unchanged, ovf<=1.
// - Pop (npop low, npush high): not empty -> depth-1, flags restored per rule 1.
//   Empty -> flags follow rules 2-4, depth stays 0, unf<=1.
// - npush and npop both low: illegal. Stack and depth unchanged, unf<=1, flags
//   follow rules 2-4.
// - No wrap-around: depth saturates at 0 and DEPTH; pointer never aliases.
// - nerrclr low clears ovf/unf at the edge. A new error in the same edge wins
//   (stays set).
// - Reset mid-sequence discards all stacked words; the next pop is an underflow.
//
// STRUCTURE
// - Shared include flags_defs.v: `define bit indices FL_V, FL_L, FL_Z, FL_N
//   and the default NFLAGS, so decode and microcode agree on bit positions.
// - Sub-module flag_lifo (DEPTH x NFLAGS): storage array, depth counter,
//   full/empty, ovf/unf. The top level holds the flag register and the
//   priority mux.
//
// TESTING
// - Reset with nreset=0 while flags=4'b1111 -> flags=0, depth=0, empty=1,
//   ovf=unf=0 within 1 ns, no clock needed.
// - nflagwe=0, ibus_f=4'b1010 -> flags=1010. Then nread_alu=0, alu_f=0101,
//   alu_mask=0011 -> flags=1001.
// - Push 8 distinct words (1..8) -> full=1, depth=8. 9th push -> ovf=1, depth=8.
//   8 pops restore 8..1 in order, then empty=1.
// - Pop when empty -> unf=1, flags unchanged. nerrclr=0 -> unf=0 next edge.
// - Same edge: npush=0 with nflagwe=0, ibus_f=0110, flags=0011 -> stack top=0011,
//   flags=0110. npop=0 with nflagwe=0 -> flags = popped word.
// - npush=npop=0 at depth 3 -> depth stays 3, unf=1. Reset at depth 5 then pop
//   -> unf=1, flags=RESET_VAL.

Source files
------------

// File: rtl/reg_flags_stk_pkg.sv
// Shared definitions for the flag register and its shadow stack: flag bit
// positions, the default flag count and the decoded stack operation.
package reg_flags_stk_pkg;

    // Flag bit positions shared by decode and microcode.
    localparam int unsigned FL_V = 0;
    localparam int unsigned FL_L = 1;
    localparam int unsigned FL_Z = 2;
    localparam int unsigned FL_N = 3;

    localparam int unsigned NFLAGS_DEF = 4;

    typedef enum logic [1:0] {
        OpNone,
        OpPush,
        OpPop,
        OpIllegal
    } stk_op_e;

    // Active-low push/pop strobes to a single stack operation; both low is illegal.
    function automatic stk_op_e decode_op(input logic npush, input logic npop);
        if (!npush && !npop) return OpIllegal;
        if (!npush)          return OpPush;
        if (!npop)           return OpPop;
        return OpNone;
    endfunction

endpackage

// File: rtl/reg_flags_stk_lifo.sv
// Flag LIFO: DEPTH x NFLAGS storage, saturating depth counter, full/empty and
// sticky overflow/underflow bits.
module reg_flags_stk_lifo
    import reg_flags_stk_pkg::*;
#(
    parameter int unsigned NFLAGS = NFLAGS_DEF,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                         clk4,
    input  logic                         nreset,
    input  stk_op_e                      op,
    input  logic                         nerrclr,
    input  logic [NFLAGS-1:0]            wdata,
    output logic [NFLAGS-1:0]            rdata,
    output logic                         pop_ok,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         empty,
    output logic                         full,
    output logic                         ovf,
    output logic                         unf
);

    localparam int unsigned PTR_W = $clog2(DEPTH + 1);
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NFLAGS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  depth_q, depth_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              is_empty, is_full, do_push;

    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == PTR_W'(DEPTH));
    assign do_push  = (op == OpPush) && !is_full;
    assign pop_ok   = (op == OpPop) && !is_empty;

    // Top of stack is the entry just below the depth count.
    assign rdata = mem[AW'(depth_q - PTR_W'(1))];

    assign depth = depth_q;
    assign empty = is_empty;
    assign full  = is_full;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

    // Next depth and sticky errors; a new error beats a same-edge clear.
    always_comb begin
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (do_push) depth_d = depth_q + PTR_W'(1);
        else if (pop_ok) depth_d = depth_q - PTR_W'(1);
        if (!nerrclr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if ((op == OpPush) && is_full) ovf_d = 1'b1;
        if (((op == OpPop) && is_empty) || (op == OpIllegal)) unf_d = 1'b1;
    end

    // Depth counter and error flags.
    always_ff @(posedge clk4 or negedge nreset) begin
        if (!nreset) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is not reset; a reset empties the stack via the depth counter alone.
    always_ff @(posedge clk4) begin
        if (do_push) mem[AW'(depth_q)] <= wdata;
    end

endmodule

// File: rtl/reg_flags_stk.sv
// Processor flag register with masked ALU load, bus load and a shadow LIFO
// used to save/restore the flag word across interrupts.
module reg_flags_stk
    import reg_flags_stk_pkg::*;
#(
    parameter int unsigned      NFLAGS    = NFLAGS_DEF,
    parameter int unsigned      DEPTH     = 8,
    parameter logic [NFLAGS-1:0] RESET_VAL = '0
) (
    input  logic                        clk4,
    input  logic                        nreset,
    input  logic [NFLAGS-1:0]           ibus_f,
    input  logic                        nflagwe,
    input  logic [NFLAGS-1:0]           alu_f,
    input  logic [NFLAGS-1:0]           alu_mask,
    input  logic                        nread_alu,
    input  logic                        npush,
    input  logic                        npop,
    input  logic                        nerrclr,
    output logic [NFLAGS-1:0]           flags,
    output logic [$clog2(DEPTH+1)-1:0]  depth,
    output logic                        empty,
    output logic                        full,
    output logic                        ovf,
    output logic                        unf
);

    logic [NFLAGS-1:0] flags_q, flags_d;
    logic [NFLAGS-1:0] stack_top;
    logic              pop_ok;
    stk_op_e           op;

    assign op    = decode_op(npush, npop);
    assign flags = flags_q;

    // Push saves the pre-edge flag word, so the LIFO writes flags_q.
    reg_flags_stk_lifo #(
        .NFLAGS (NFLAGS),
        .DEPTH  (DEPTH)
    ) u_lifo (
        .clk4    (clk4),
        .nreset  (nreset),
        .op      (op),
        .nerrclr (nerrclr),
        .wdata   (flags_q),
        .rdata   (stack_top),
        .pop_ok  (pop_ok),
        .depth   (depth),
        .empty   (empty),
        .full    (full),
        .ovf     (ovf),
        .unf     (unf)
    );

    // Priority mux: restore, then bus load, then masked ALU load, else hold.
    always_comb begin
        flags_d = flags_q;
        if (pop_ok) begin
            flags_d = stack_top;
        end else if (!nflagwe) begin
            flags_d = ibus_f;
        end else if (!nread_alu) begin
            flags_d = (flags_q & ~alu_mask) | (alu_f & alu_mask);
        end
    end

    // Flag register.
    always_ff @(posedge clk4 or negedge nreset) begin
        if (!nreset) flags_q <= RESET_VAL;
        else         flags_q <= flags_d;
    end

endmodule

// File: tb/tb_reg_flags_stk.sv
// Self-checking bench for reg_flags_stk with a behavioural model and scoreboard.
module tb_reg_flags_stk;

    localparam int unsigned NF    = 4;
    localparam int unsigned DEPTH = 8;
    localparam logic [NF-1:0] RV  = 4'b0000;

    logic          clk4 = 1'b0;
    logic          nreset;
    logic [NF-1:0] ibus_f, alu_f, alu_mask;
    logic          nflagwe, nread_alu, npush, npop, nerrclr;
    logic [NF-1:0] flags;
    logic [3:0]    depth;
    logic          empty, full, ovf, unf;

    reg_flags_stk #(
        .NFLAGS    (NF),
        .DEPTH     (DEPTH),
        .RESET_VAL (RV)
    ) dut (
        .clk4      (clk4),
        .nreset    (nreset),
        .ibus_f    (ibus_f),
        .nflagwe   (nflagwe),
        .alu_f     (alu_f),
        .alu_mask  (alu_mask),
        .nread_alu (nread_alu),
        .npush     (npush),
        .npop      (npop),
        .nerrclr   (nerrclr),
        .flags     (flags),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk4 = ~clk4;

    typedef struct {
        logic [NF-1:0] flags;
        int            depth;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t          sb[$];
    logic [NF-1:0] m_stack[$];
    logic [NF-1:0] m_flags;
    logic          m_ovf, m_unf;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        nflagwe   = 1'b1;
        nread_alu = 1'b1;
        npush     = 1'b1;
        npop      = 1'b1;
        nerrclr   = 1'b1;
        ibus_f    = '0;
        alu_f     = '0;
        alu_mask  = '0;
    endtask

    // Model one edge from the driven inputs, queue the expectation, then compare.
    task automatic tick(input string tag);
        exp_t          e;
        logic          push, pop, pop_ok, unf_set, ovf_set;
        logic [NF-1:0] nf;
        push    = !npush;
        pop     = !npop;
        pop_ok  = pop && !push && (m_stack.size() > 0);
        unf_set = (pop && push) || (pop && !push && (m_stack.size() == 0));
        ovf_set = push && !pop && (m_stack.size() == DEPTH);
        if (pop_ok)          nf = m_stack[$];
        else if (!nflagwe)   nf = ibus_f;
        else if (!nread_alu) nf = (m_flags & ~alu_mask) | (alu_f & alu_mask);
        else                 nf = m_flags;
        if (push && !pop && !ovf_set) m_stack.push_back(m_flags);
        if (pop_ok) void'(m_stack.pop_back());
        if (!nerrclr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (ovf_set) m_ovf = 1'b1;
        if (unf_set) m_unf = 1'b1;
        m_flags = nf;
        e.flags = m_flags;
        e.depth = m_stack.size();
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        sb.push_back(e);

        @(posedge clk4);
        #1;
        e = sb.pop_front();
        chk({tag, ".flags"}, 32'(flags), 32'(e.flags));
        chk({tag, ".depth"}, 32'(depth), 32'(e.depth));
        chk({tag, ".empty"}, 32'(empty), 32'(e.depth == 0));
        chk({tag, ".full"},  32'(full),  32'(e.depth == DEPTH));
        chk({tag, ".ovf"},   32'(ovf),   32'(e.ovf));
        chk({tag, ".unf"},   32'(unf),   32'(e.unf));
        idle();
    endtask

    // Asynchronous reset between edges; outputs must settle without a clock.
    task automatic async_reset(input string tag);
        nreset = 1'b0;
        #1;
        m_flags = RV;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        chk({tag, ".flags"}, 32'(flags), 32'(RV));
        chk({tag, ".depth"}, 32'(depth), 32'd0);
        chk({tag, ".empty"}, 32'(empty), 32'd1);
        chk({tag, ".full"},  32'(full),  32'd0);
        chk({tag, ".ovf"},   32'(ovf),   32'd0);
        chk({tag, ".unf"},   32'(unf),   32'd0);
        #1;
        nreset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        nreset  = 1'b0;
        m_flags = RV;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        #3 nreset = 1'b1;

        // Load all ones, then reset with no clock edge.
        nflagwe = 1'b0; ibus_f = 4'b1111; tick("load_1111");
        async_reset("rst_async");

        // Bus load then masked ALU load.
        nflagwe = 1'b0; ibus_f = 4'b1010; tick("bus_1010");
        nread_alu = 1'b0; alu_f = 4'b0101; alu_mask = 4'b0011; tick("alu_masked");

        // Fill the stack with 1..8, then overflow.
        for (int k = 1; k <= 8; k++) begin
            nflagwe = 1'b0; ibus_f = 4'(k); tick("fill_load");
            npush = 1'b0; tick("fill_push");
        end
        nflagwe = 1'b0; ibus_f = 4'b1111; tick("pre_ovf_load");
        npush = 1'b0; tick("push_full");
        nerrclr = 1'b0; tick("clr_ovf");
        for (int k = 0; k < 8; k++) begin
            npop = 1'b0; tick("drain_pop");
        end

        // Underflow on empty, then clear.
        npop = 1'b0; tick("pop_empty");
        nerrclr = 1'b0; tick("clr_unf");

        // Push with same-edge bus load; pop wins over same-edge bus load.
        nflagwe = 1'b0; ibus_f = 4'b0011; tick("load_0011");
        npush = 1'b0; nflagwe = 1'b0; ibus_f = 4'b0110; tick("push_and_load");
        npop = 1'b0; nflagwe = 1'b0; ibus_f = 4'b1111; tick("pop_and_load");

        // Illegal push+pop at depth 3; error set beats a same-edge clear.
        for (int k = 0; k < 3; k++) begin
            nflagwe = 1'b0; ibus_f = 4'(k + 9); tick("d3_load");
            npush = 1'b0; tick("d3_push");
        end
        npush = 1'b0; npop = 1'b0; nflagwe = 1'b0; ibus_f = 4'b0101; tick("push_pop_illegal");
        npush = 1'b0; npop = 1'b0; nerrclr = 1'b0; tick("illegal_vs_clr");
        nerrclr = 1'b0; tick("clr_after_illegal");

        // Reset at depth 5 discards the stack; next pop underflows.
        for (int k = 0; k < 2; k++) begin
            npush = 1'b0; tick("d5_push");
        end
        async_reset("rst_d5");
        npop = 1'b0; tick("pop_after_rst");

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            ibus_f    = 4'($urandom);
            alu_f     = 4'($urandom);
            alu_mask  = 4'($urandom);
            nflagwe   = ($urandom_range(0, 3) != 0);
            nread_alu = ($urandom_range(0, 2) != 0);
            npush     = ($urandom_range(0, 2) != 0);
            npop      = ($urandom_range(0, 2) != 0);
            nerrclr   = ($urandom_range(0, 7) != 0);
            tick("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
